record_stepper: RTL

Drains 16-bit motion records from the SPI-fed record FIFO and plays each one out as step/direction pulses on the board's pin outputs (p1..p8 = step[3:0], dir[3:0]). It is the reader at the far end of the SPI → FIFO path. Each record carries an axis mask, per-axis direction bits and a step count. It emits that many equally spaced step pulses, then fetches the next record.

---
 rtl/record_stepper_pkg.sv | 38 +++
 rtl/record_stepper_if.sv | 28 ++
 rtl/record_stepper_step_timer.sv | 35 +++
 rtl/record_stepper.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/record_stepper_pkg.sv
// Shared types and record-layout helpers for the record_stepper block.
// The record is {count, dir, mask} packed LSB-first into the FIFO word.
package record_stepper_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_SETUP,
      ST_PULSE,
      ST_GAP
   } state_e;

   localparam int DEF_AXES        = 4;
   localparam int DEF_COUNT_WIDTH = 8;

   function automatic int field_dir_lsb(input int axes);
      return axes;
   endfunction

   function automatic int field_cnt_lsb(input int axes);
      return 2 * axes;
   endfunction

   function automatic int rec_width(input int axes, input int count_width);
      return 2 * axes + count_width;
   endfunction

   // Default build matches the FIFO's two-byte record.
   localparam int REC_WIDTH = rec_width(DEF_AXES, DEF_COUNT_WIDTH);

   function automatic int timer_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/record_stepper_if.sv
// FIFO-side handshake plus step/dir pin bundle of the record_stepper.
// master = the stepper, slave = the FIFO / board environment.
interface record_stepper_if #(
   parameter int AXES        = 4,
   parameter int COUNT_WIDTH = 8
);
   import record_stepper_pkg::*;

   logic                                    enable;
   logic                                    fifo_empty;
   logic [rec_width(AXES, COUNT_WIDTH)-1:0] fifo_data;
   logic                                    fifo_read_en;
   logic [AXES-1:0]                         step;
   logic [AXES-1:0]                         dir;
   logic                                    busy;
   logic                                    underrun;

   modport master (
      input  enable, fifo_empty, fifo_data,
      output fifo_read_en, step, dir, busy, underrun
   );

   modport slave (
      output enable, fifo_empty, fifo_data,
      input  fifo_read_en, step, dir, busy, underrun
   );

endinterface

// File: rtl/record_stepper_step_timer.sv
// Loadable down-counter shared by the SETUP, PULSE and GAP phases.
// tc_o is high while the count sits at zero; freeze_i holds the count.
module step_timer #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             freeze_i,
   output logic             tc_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (!freeze_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/record_stepper.sv
// Pops motion records from the FIFO and plays them out as step/dir pulses.
// Optional sticky underrun flag is built only with RECORD_STEPPER_UNDERRUN_EN.
module record_stepper
   import record_stepper_pkg::*;
#(
   parameter int AXES        = DEF_AXES,
   parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
   parameter int STEP_PERIOD = 8,
   parameter int PULSE_WIDTH = 2,
   parameter int DIR_SETUP   = 3
) (
   input  logic                clk,
   input  logic                rst,
   record_stepper_if.master    bus
);

   localparam int TW      = timer_width(STEP_PERIOD, DIR_SETUP);
   localparam int DIR_LSB = field_dir_lsb(AXES);
   localparam int CNT_LSB = field_cnt_lsb(AXES);

   // Timer terminates at zero, so each phase loads its length minus one.
   localparam logic [TW-1:0] SETUP_LOAD = TW'(DIR_SETUP - 1);
   localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_WIDTH - 1);
   localparam logic [TW-1:0] GAP_LOAD   = TW'(STEP_PERIOD - PULSE_WIDTH - 1);

   state_e                 state_q, state_d;
   logic [AXES-1:0]        mask_q, mask_d;
   logic [AXES-1:0]        dir_q, dir_d;
   logic [AXES-1:0]        step_q, step_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;

   logic                   tmr_load;
   logic [TW-1:0]          tmr_val;
   logic                   tmr_freeze;
   logic                   tmr_tc;

   step_timer #(
      .WIDTH (TW)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .freeze_i   (tmr_freeze),
      .tc_o       (tmr_tc)
   );

   always_comb begin
      state_d    = state_q;
      mask_d     = mask_q;
      dir_d      = dir_q;
      count_d    = count_q;
      tmr_load   = 1'b0;
      tmr_val    = '0;
      tmr_freeze = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.enable && !bus.fifo_empty) begin
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            state_d = ST_LOAD;
         end
         ST_LOAD: begin
            mask_d  = bus.fifo_data[AXES-1:0];
            dir_d   = bus.fifo_data[DIR_LSB +: AXES];
            count_d = bus.fifo_data[CNT_LSB +: COUNT_WIDTH];
            if (count_d == '0) begin
               state_d = ST_IDLE;
            end else begin
               state_d  = ST_SETUP;
               tmr_load = 1'b1;
               tmr_val  = SETUP_LOAD;
            end
         end
         ST_SETUP: begin
            if (tmr_tc) begin
               state_d  = ST_PULSE;
               tmr_load = 1'b1;
               tmr_val  = PULSE_LOAD;
            end
         end
         ST_PULSE: begin
            if (tmr_tc) begin
               state_d  = ST_GAP;
               tmr_load = 1'b1;
               tmr_val  = GAP_LOAD;
            end
         end
         ST_GAP: begin
            // Only the gap stretches while enable is low; pulses always finish.
            tmr_freeze = !bus.enable;
            if (tmr_tc && bus.enable) begin
               if (count_q != '0) begin
                  count_d = count_q - COUNT_WIDTH'(1);
               end
               if (count_q <= COUNT_WIDTH'(1)) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d  = ST_PULSE;
                  tmr_load = 1'b1;
                  tmr_val  = PULSE_LOAD;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   for (genvar gi = 0; gi < AXES; gi++) begin : g_step
      assign step_d[gi] = (state_d == ST_PULSE) & mask_d[gi];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         mask_q  <= '0;
         dir_q   <= '0;
         count_q <= '0;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         dir_q   <= dir_d;
         count_q <= count_d;
         step_q  <= step_d;
      end
   end

   assign bus.fifo_read_en = (state_q == ST_FETCH);
   assign bus.busy         = (state_q != ST_IDLE);
   assign bus.step         = step_q;
   assign bus.dir          = dir_q;

`ifdef RECORD_STEPPER_UNDERRUN_EN
   logic underrun_q, underrun_d;

   always_comb begin
      underrun_d = underrun_q;
      if ((state_q == ST_GAP) && tmr_tc && bus.enable &&
          (count_q == COUNT_WIDTH'(1)) && bus.fifo_empty) begin
         underrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         underrun_q <= 1'b0;
      end else begin
         underrun_q <= underrun_d;
      end
   end

   assign bus.underrun = underrun_q;
`else
   assign bus.underrun = 1'b0;
`endif

endmodule
